ksm_busarb: RTL and testbench
=============================

Name: ksm_busarb

Overview:
Two-master Wishbone arbiter and bus watchdog for the KSM terminal system bus. Master 0 is the VM2 CPU; its grant output drives the CPU wbm_gnt_i. Master 1 is a secondary bus master, for example a video-RAM scroll/fill engine. The block owns the shared slave-side bus (RAM, UART, video RAM, vregs, PS/2) and grants it per Wishbone cycle, using round-robin when both masters request together. An optional watchdog terminates cycles that no slave acknowledges.

Parameters:
AW, 16, address width
DW, 16, data width
TIMEOUT, 255, watchdog limit in wait-state cycles, legal range 2..1023

Ports:
wb_clk_i  in  1  system clock (clk50)
wb_rst_i  in  1  synchronous active-high reset
m0_cyc_i  in  1  master 0 cycle
m0_stb_i  in  1  master 0 strobe
m0_we_i  in  1  master 0 write enable
m0_adr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_sel_i  in  2  master 0 byte selects
m0_gnt_o  out  1  master 0 owns the bus
m0_ack_o  out  1  master 0 acknowledge
m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i  in  as for master 0  master 1 request bus
m1_gnt_o  out  1  master 1 owns the bus
m1_ack_o  out  1  master 1 acknowledge
m_dat_o  out  DW  read data, shared by both masters
s_cyc_o  out  1  slave-side cycle
s_stb_o  out  1  slave-side strobe
s_we_o  out  1  slave-side write enable
s_adr_o  out  AW  slave-side address
s_dat_o  out  DW  slave-side write data
s_sel_o  out  2  slave-side byte selects
s_ack_i  in  1  ORed slave acknowledge
s_dat_i  in  DW  muxed slave read data
to_err_o  out  1  one-cycle pulse on watchdog termination

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_i is synchronous, active-high.
- Reset values: state IDLE; m0_gnt_o=m1_gnt_o=0; last=1, so master 0 wins the first tie; watchdog counter 0; to_err_o=0.
- State machine:
  - IDLE to OWN0: m0_cyc_i & ~m1_cyc_i.
  - IDLE to OWN1: m1_cyc_i & ~m0_cyc_i.
  - IDLE with both requesting: go to OWN0 if last==1, else OWN1.
  - OWNx while mx_cyc_i=1: stay; no preemption, even mid-burst.
  - OWNx when mx_cyc_i=0: hand off directly to OWNy if my_cyc_i=1, otherwise go to IDLE.
  - last is updated to x on every entry into OWNx.
- Grant latency: registered grant, one cycle after the cyc request is sampled in IDLE. A handoff has zero dead cycles: the new grant is asserted in the cycle after the old cyc is seen low.
- gnt outputs: mx_gnt_o = (state==OWNx). They are never both high.
- Slave-side mux (combinational from state):
  - In OWNx: s_* = mx_*, with s_cyc_o=mx_cyc_i and s_stb_o=mx_stb_i.
  - In IDLE: s_cyc_o=s_stb_o=0; other s_* carry master 0 signals.
- Acknowledge routing:
  - mx_ack_o = (state==OWNx) & mx_cyc_i & mx_stb_i & (s_ack_i | wd_fire), combinational in the same cycle.
  - The non-owner never sees ack.
- Read data: m_dat_o = wd_fire ? 0 : s_dat_i.
- Simultaneous events:
  - Owner cyc falls in the same cycle as its ack: legal; the cycle completes and handoff follows next cycle.
  - s_ack_i while IDLE: ignored.
- Reset mid-cycle: grants drop in the next cycle and the slave side goes idle. Any in-flight transfer is abandoned with no ack.

Optional Feature:
Macro KSM_BUSARB_TIMEOUT_EN.
- Defined:
  - A 10-bit counter increments each cycle s_stb_o & ~s_ack_i.
  - It clears on s_ack_i, on ~s_stb_o, on reset, and on fire.
  - When the counter equals TIMEOUT-1 and the wait continues, wd_fire=1 for one cycle: the owner receives ack with m_dat_o=0, to_err_o pulses, and the counter clears.
  - Writes are discarded.
- Undefined: no counter; wd_fire=0; to_err_o tied 0; an unacknowledged cycle hangs indefinitely.

Test Plan:
- Reset, then m0_cyc_i=1: m0_gnt_o=1 exactly one cycle later. A read at 0o001000 with the slave returning 0o123456 makes m0_ack_o=1 and m_dat_o=0o123456; m1_ack_o stays 0.
- Both cyc rise together after reset: OWN0 first. When m0 drops cyc, m1_gnt_o=1 the next cycle with no IDLE cycle. The next simultaneous tie goes to master 0, since last=1.
- m1 holds cyc through 4 back-to-back writes while m0 requests: no preemption; m0_gnt_o rises only the cycle after m1_cyc_i falls.
- Reset asserted while OWN1 has stb high: the next cycle has both grants 0 and s_cyc_o=0; the following m0-only request is granted normally.
- With KSM_BUSARB_TIMEOUT_EN and TIMEOUT=8, m0 reads 0o177000 (unmapped, no ack): m0_ack_o and to_err_o pulse on the 8th wait cycle, with m_dat_o=0.
- Without the macro, the same stimulus: no ack after 1000 cycles and to_err_o stays 0.

Source files
------------

// File: rtl/ksm_busarb_if.sv
// rtl/ksm_busarb_if.sv - Bus bundle between the two KSM masters, the arbiter and the shared slave side.
interface ksm_busarb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic          m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [1:0]    m0_sel_i;
    logic          m0_gnt_o;
    logic          m0_ack_o;

    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic          m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [1:0]    m1_sel_i;
    logic          m1_gnt_o;
    logic          m1_ack_o;

    logic [DW-1:0] m_dat_o;

    logic          s_cyc_o;
    logic          s_stb_o;
    logic          s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [1:0]    s_sel_o;
    logic          s_ack_i;
    logic [DW-1:0] s_dat_i;

    logic          to_err_o;

    // Arbiter view: it answers both masters and drives the slave side.
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        input  s_ack_i, s_dat_i,
        output m0_gnt_o, m0_ack_o, m1_gnt_o, m1_ack_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output to_err_o
    );

    // Environment view: the masters plus the slave fabric around the arbiter.
    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        output s_ack_i, s_dat_i,
        input  m0_gnt_o, m0_ack_o, m1_gnt_o, m1_ack_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  to_err_o
    );
endinterface

// File: rtl/ksm_busarb.sv
// rtl/ksm_busarb.sv - Two-master round-robin Wishbone arbiter with optional watchdog (KSM_BUSARB_TIMEOUT_EN).
module ksm_busarb #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    ksm_busarb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   wd_fire;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Ownership lasts the whole cyc; a released bus goes straight to the other requester.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && !bus.m1_cyc_i)      state_d = OWN0;
                else if (bus.m1_cyc_i && !bus.m0_cyc_i) state_d = OWN1;
                else if (bus.m0_cyc_i && bus.m1_cyc_i)  state_d = last_q ? OWN0 : OWN1;
            end
            OWN0: begin
                if (!bus.m0_cyc_i) state_d = bus.m1_cyc_i ? OWN1 : IDLE;
            end
            OWN1: begin
                if (!bus.m1_cyc_i) state_d = bus.m0_cyc_i ? OWN0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == OWN0 && state_q != OWN0) last_d = 1'b0;
        if (state_d == OWN1 && state_q != OWN1) last_d = 1'b1;
    end

    always_comb begin
        bus.m0_gnt_o = (state_q == OWN0);
        bus.m1_gnt_o = (state_q == OWN1);
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        if (state_q == OWN0) begin
            bus.s_cyc_o = bus.m0_cyc_i;
            bus.s_stb_o = bus.m0_stb_i;
        end else if (state_q == OWN1) begin
            bus.s_cyc_o = bus.m1_cyc_i;
            bus.s_stb_o = bus.m1_stb_i;
            bus.s_we_o  = bus.m1_we_i;
            bus.s_adr_o = bus.m1_adr_i;
            bus.s_dat_o = bus.m1_dat_i;
            bus.s_sel_o = bus.m1_sel_i;
        end
    end

    // Acks are masked during reset so an abandoned transfer never completes.
    always_comb begin
        bus.m0_ack_o = !wb_rst_i && (state_q == OWN0) && bus.m0_cyc_i && bus.m0_stb_i
                       && (bus.s_ack_i || wd_fire);
        bus.m1_ack_o = !wb_rst_i && (state_q == OWN1) && bus.m1_cyc_i && bus.m1_stb_i
                       && (bus.s_ack_i || wd_fire);
        bus.m_dat_o  = wd_fire ? '0 : bus.s_dat_i;
    end

`ifdef KSM_BUSARB_TIMEOUT_EN
    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT - 1);

    logic [9:0] wd_cnt_q, wd_cnt_d;
    logic       wd_wait;

    assign wd_wait = bus.s_stb_o && !bus.s_ack_i;
    assign wd_fire = !wb_rst_i && wd_wait && (wd_cnt_q == WD_LIMIT);

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (!wd_wait || wd_fire) wd_cnt_d = '0;
        else                     wd_cnt_d = wd_cnt_q + 10'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) wd_cnt_q <= '0;
        else          wd_cnt_q <= wd_cnt_d;
    end

    assign bus.to_err_o = wd_fire;
`else
    assign wd_fire      = 1'b0;
    assign bus.to_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ksm_busarb.sv
// tb/tb_ksm_busarb.sv - Directed self-checking bench for ksm_busarb.
module tb_ksm_busarb;
    localparam int AW = 16;
    localparam int DW = 16;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ksm_busarb_if #(.AW(AW), .DW(DW)) bus ();

    ksm_busarb #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus.slave)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;
        bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_sel_i = 2'b11;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
        bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_sel_i = 2'b11;
        bus.s_ack_i  = 0; bus.s_dat_i = '0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        step();
        step();
        wb_rst_i = 1'b0;
    endtask

    initial begin
        int ack_seen;
        int err_seen;
        idle_inputs();
        do_reset();
        #1;
        chk("rst_gnt0", bus.m0_gnt_o, 1'b0);
        chk("rst_gnt1", bus.m1_gnt_o, 1'b0);
        chk("rst_scyc", bus.s_cyc_o, 1'b0);
        chk("rst_toerr", bus.to_err_o, 1'b0);

        // m0 read: grant one cycle after request
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 16'o001000;
        bus.s_ack_i = 1; bus.s_dat_i = 16'o123456;
        #1;
        chk("t1_gnt0_lat", bus.m0_gnt_o, 1'b0);
        chk("t1_idle_ack", bus.m0_ack_o, 1'b0);
        step();
        chk("t1_gnt0", bus.m0_gnt_o, 1'b1);
        chk("t1_sadr", bus.s_adr_o, 16'o001000);
        chk("t1_ack0", bus.m0_ack_o, 1'b1);
        chk("t1_dat", bus.m_dat_o, 16'o123456);
        chk("t1_ack1", bus.m1_ack_o, 1'b0);
        idle_inputs();
        step();
        chk("t1_release", bus.m0_gnt_o, 1'b0);

        // simultaneous request after reset: master 0 first, then direct handoff
        do_reset();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 16'h0100;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 16'h0200;
        step();
        chk("t2_gnt0", bus.m0_gnt_o, 1'b1);
        chk("t2_gnt1_lo", bus.m1_gnt_o, 1'b0);
        chk("t2_sadr0", bus.s_adr_o, 16'h0100);
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        step();
        chk("t2_handoff1", bus.m1_gnt_o, 1'b1);
        chk("t2_handoff0", bus.m0_gnt_o, 1'b0);
        chk("t2_sadr1", bus.s_adr_o, 16'h0200);
        bus.s_ack_i = 1;
        #1;
        chk("t2_ack1", bus.m1_ack_o, 1'b1);
        chk("t2_ack0", bus.m0_ack_o, 1'b0);
        idle_inputs();
        step();
        chk("t2_idle", bus.m1_gnt_o, 1'b0);
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
        step();
        chk("t2_tie_gnt0", bus.m0_gnt_o, 1'b1);
        chk("t2_tie_gnt1", bus.m1_gnt_o, 1'b0);
        idle_inputs();
        step();

        // m1 burst of 4 writes, m0 waiting: no preemption
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1;
        step();
        chk("t3_gnt1", bus.m1_gnt_o, 1'b1);
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
        for (int i = 0; i < 4; i++) begin
            bus.m1_adr_i = 16'(16'h0400 + i);
            bus.m1_dat_i = 16'(16'hA000 + i);
            bus.s_ack_i  = 1;
            #1;
            chk("t3_ack1", bus.m1_ack_o, 1'b1);
            chk("t3_sdat", bus.s_dat_o, 32'(16'hA000 + i));
            chk("t3_swe", bus.s_we_o, 1'b1);
            chk("t3_nopreempt", bus.m0_gnt_o, 1'b0);
            step();
        end
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.s_ack_i = 0;
        #1;
        chk("t3_still1", bus.m1_gnt_o, 1'b1);
        chk("t3_still0", bus.m0_gnt_o, 1'b0);
        step();
        chk("t3_gnt0", bus.m0_gnt_o, 1'b1);
        chk("t3_gnt1_lo", bus.m1_gnt_o, 1'b0);

        // reset while OWN1 has stb high
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
        step();
        chk("t4_gnt1", bus.m1_gnt_o, 1'b1);
        wb_rst_i = 1; bus.s_ack_i = 1;
        #1;
        chk("t4_rst_noack", bus.m1_ack_o, 1'b0);
        step();
        chk("t4_gnt0", bus.m0_gnt_o, 1'b0);
        chk("t4_gnt1", bus.m1_gnt_o, 1'b0);
        chk("t4_scyc", bus.s_cyc_o, 1'b0);
        wb_rst_i = 0;
        idle_inputs();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
        step();
        chk("t4_regrant", bus.m0_gnt_o, 1'b1);
        idle_inputs();
        step();

        // unacknowledged read of an unmapped address
        do_reset();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 16'o177000;
        bus.s_dat_i = 16'hBEEF;
`ifdef KSM_BUSARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t5_ack", bus.m0_ack_o, (k == 8) ? 1'b1 : 1'b0);
            chk("t5_toerr", bus.to_err_o, (k == 8) ? 1'b1 : 1'b0);
        end
        chk("t5_dat0", bus.m_dat_o, 16'h0000);
        step();
        chk("t5_after_ack", bus.m0_ack_o, 1'b0);
        chk("t5_after_err", bus.to_err_o, 1'b0);
`else
        ack_seen = 0;
        err_seen = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (bus.m0_ack_o) ack_seen++;
            if (bus.to_err_o) err_seen++;
        end
        chk("t5_hang_ack", 32'(ack_seen), 32'd0);
        chk("t5_hang_err", 32'(err_seen), 32'd0);
        chk("t5_hang_gnt", bus.m0_gnt_o, 1'b1);
`endif
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
